// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM states,
// default operand width and the iteration counter width.
package shift_add_multiplier_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   // Guards the degenerate WIDTH=1 case so the counter never collapses to zero bits
   function automatic int count_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int COUNT_W = count_width(DEFAULT_WIDTH);

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/result handshake bundle shared by the multiplier and its requester;
// same shape as the restoring divider's port group.
interface shift_add_multiplier_if
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic                 start;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  start, multiplicand, multiplier,
      output busy, done, product
   );

endinterface

// File: rtl/shift_add_multiplier_add_shift_unit.sv
// One multiplier iteration: conditionally add M into the accumulator, then
// shift the {carry, A, Q} chain right by one bit.
module add_shift_unit
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH:0]   next_a,
   output logic [WIDTH-1:0] next_q
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum    = {1'b0, a} + (q[0] ? {1'b0, m} : '0);
      next_a = {1'b0, sum[WIDTH:1]};
      next_q = {sum[0], q[WIDTH-1:1]};
   end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: WIDTH add/shift steps per product,
// fixed latency, one-cycle done pulse, product held until the next result.
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   shift_add_multiplier_if.slave bus
);

   localparam int                 CNT_W = count_width(WIDTH);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

   state_t              state_q;
   state_t              state_d;
   logic                load;
   logic                step;
   logic                last;

   logic [WIDTH:0]      a_q;
   logic [WIDTH-1:0]    q_q;
   logic [WIDTH-1:0]    m_q;
   logic [CNT_W-1:0]    count_q;
   logic [2*WIDTH-1:0]  product_q;

   logic [WIDTH:0]      next_a;
   logic [WIDTH-1:0]    next_q;

   // The shift always clears the top accumulator bit; it is kept so the
   // register layout matches the divider's A register.
   logic                unused_carry;
   assign unused_carry = a_q[WIDTH];

   add_shift_unit #(
      .WIDTH (WIDTH)
   ) u_add_shift (
      .a      (a_q[WIDTH-1:0]),
      .q      (q_q),
      .m      (m_q),
      .next_a (next_a),
      .next_q (next_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = IDLE;
      load    = 1'b0;
      step    = 1'b0;
      last    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (count_q == LAST) begin
               last    = 1'b1;
               state_d = DONE;
            end else begin
               state_d = CALC;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         q_q       <= '0;
         m_q       <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else if (load) begin
         a_q     <= '0;
         q_q     <= bus.multiplier;
         m_q     <= bus.multiplicand;
         count_q <= '0;
      end else if (step) begin
         a_q     <= next_a;
         q_q     <= next_q;
         count_q <= count_q + CNT_W'(1);
         // Final step: the shifted {A,Q} is the full product
         if (last) begin
            product_q <= {next_a[WIDTH-1:0], next_q};
         end
      end
   end

   assign bus.busy    = (state_q == CALC) || (state_q == DONE);
   assign bus.done    = (state_q == DONE);
   assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: directed corner cases plus a
// random regression checked against plain M*Q arithmetic.
module tb_shift_add_multiplier;
   import shift_add_multiplier_pkg::*;

   localparam int W = 16;

   typedef struct {
      logic [2*W-1:0] prod;
      int             done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   next_free = 0;
   exp_t exp_q[$];

   logic [2*W-1:0] prev_product = '0;
   logic           prev_done = 1'b0;

   shift_add_multiplier_if #(.WIDTH(W)) bus ();

   shift_add_multiplier #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
      end
   endtask

   // Reference model: a request is served only when the unit has finished
   // its previous job (WIDTH+2 edges per product); result is exact M*Q.
   task automatic drive_start(input logic [W-1:0] m, input logic [W-1:0] q);
      int edge_c;
      logic [2*W-1:0] p;
      bus.start        = 1'b1;
      bus.multiplicand = m;
      bus.multiplier   = q;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      edge_c = cyc;
      if (edge_c >= next_free) begin
         p = {{W{1'b0}}, m} * {{W{1'b0}}, q};
         exp_q.push_back('{prod: p, done_cyc: edge_c + W});
         next_free = edge_c + W + 2;
         check("busy_rise", {63'd0, bus.busy}, 64'd1);
      end
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int i = 0; i < 3 * W + 10; i++) begin
         if (exp_q.size() == 0) begin
            idle = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!idle) check("wait_idle_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: scoreboard pop on done, plus protocol invariants every cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_product = bus.product;
         prev_done    = 1'b0;
      end else begin
         if (prev_done) begin
            check("done_single", {63'd0, bus.done}, 64'd0);
            check("busy_fall", {63'd0, bus.busy}, 64'd0);
         end
         if (!bus.done) check("product_stable", 64'(bus.product), 64'(prev_product));
         if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
            check("done_timeout", 64'(cyc), 64'(exp_q[0].done_cyc));
            void'(exp_q.pop_front());
         end
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", {63'd0, bus.done}, 64'd0);
            end else begin
               check("latency", 64'(cyc), 64'(exp_q[0].done_cyc));
               check("product", 64'(bus.product), 64'(exp_q[0].prod));
               check("busy_in_done", {63'd0, bus.busy}, 64'd1);
               void'(exp_q.pop_front());
            end
         end
         prev_product = bus.product;
         prev_done    = bus.done;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n            = 1'b0;
      bus.start        = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      #1;
      check("reset_busy", {63'd0, bus.busy}, 64'd0);
      check("reset_done", {63'd0, bus.done}, 64'd0);
      check("reset_product", 64'(bus.product), 64'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      drive_start(16'd3, 16'd5);
      wait_idle();
      drive_start(16'hFFFF, 16'hFFFF);
      wait_idle();
      drive_start(16'h0000, 16'hABCD);
      wait_idle();
      drive_start(16'h1234, 16'h0000);
      wait_idle();

      // Extra starts and operand churn during CALC and DONE must be ignored
      begin
         int e;
         drive_start(16'd7, 16'd9);
         e = cyc;
         drive_start(16'd2, 16'd2);
         while (cyc < e + W + 1) drive_start(W'($urandom), W'($urandom));
         drive_start(16'd2, 16'd2);
         wait_idle();
      end

      // Asynchronous abort mid-calculation
      drive_start(16'd100, 16'd100);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      next_free = 0;
      #1;
      check("abort_busy", {63'd0, bus.busy}, 64'd0);
      check("abort_done", {63'd0, bus.done}, 64'd0);
      check("abort_product", 64'(bus.product), 64'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      drive_start(16'd100, 16'd100);
      wait_idle();

      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] m;
         logic [W-1:0] q;
         m = W'($urandom);
         q = W'($urandom);
         if (i % 97 == 0) m = '1;
         if (i % 89 == 0) q = '1;
         drive_start(m, q);
         wait_idle();
      end

      repeat (4) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
